// File: rtl/mfhwt_pkg.sv
// Shared definitions for the MFHWT demux controller: FSM encoding, lane count
// and the lane-to-write-enable decode.
package mfhwt_pkg;

   localparam int NUM_LANES = 4;
   localparam int LANE_W    = $clog2(NUM_LANES);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
      logic [NUM_LANES-1:0] oh;
      oh       = '0;
      oh[lane] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mfhwt_raster_cnt.sv
// Raster position counters: column within a row, lane (row buffer) within a band,
// and band within a frame, each with a terminal-count flag.
module mfhwt_raster_cnt
   import mfhwt_pkg::*;
#(
   parameter int  IMG_W  = 320,
   parameter int  IMG_H  = 240,
   localparam int COL_W  = $clog2(IMG_W),
   localparam int BAND_W = (IMG_H / 4 > 1) ? $clog2(IMG_H / 4) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              col_en_i,
   input  logic              band_inc_i,
   output logic [COL_W-1:0]  col_o,
   output logic [LANE_W-1:0] lane_o,
   output logic [BAND_W-1:0] band_o,
   output logic              col_last_o,
   output logic              lane_last_o,
   output logic              band_last_o
);

   logic [COL_W-1:0]  col_q,  col_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [BAND_W-1:0] band_q, band_d;

   assign col_last_o  = (col_q  == COL_W'(IMG_W - 1));
   assign lane_last_o = (lane_q == LANE_W'(NUM_LANES - 1));
   assign band_last_o = (band_q == BAND_W'(IMG_H / 4 - 1));

   assign col_o  = col_q;
   assign lane_o = lane_q;
   assign band_o = band_q;

   // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
   always_comb begin
      col_d  = col_q;
      lane_d = lane_q;
      band_d = band_q;
      if (clr_i) begin
         col_d  = '0;
         lane_d = '0;
         band_d = '0;
      end else begin
         if (col_en_i) begin
            if (col_last_o) begin
               col_d  = '0;
               lane_d = lane_q + 1'b1;  // wraps 3 -> 0 on its own
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         if (band_inc_i) begin
            band_d = band_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignment only, so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         lane_q <= '0;
         band_q <= '0;
      end else begin
         col_q  <= col_d;
         lane_q <= lane_d;
         band_q <= band_d;
      end
   end

endmodule

// File: rtl/mfhwt_demux_ctrl.sv
// MFHWT 1-to-4 demux sequencer: steers raster rows into four line buffers,
// raises a band-ready flag every four rows and stalls the source until acked.
module mfhwt_demux_ctrl
   import mfhwt_pkg::*;
#(
   parameter int  IMG_W  = 320,
   parameter int  IMG_H  = 240,
   parameter int  DATA_W = 16,
   localparam int ADDR_W = $clog2(IMG_W),
   localparam int BAND_W = (IMG_H / 4 > 1) ? $clog2(IMG_H / 4) : 1
) (
   input  logic                 iclk,
   input  logic                 irst_n,
   input  logic                 istart,
   input  logic                 ivalid,
   input  logic [DATA_W-1:0]    idata,
   output logic                 oready,
   output logic [DATA_W-1:0]    odata,
   output logic [LANE_W-1:0]    osel,
   output logic [NUM_LANES-1:0] owe,
   output logic [ADDR_W-1:0]    oaddr,
   output logic                 orow_done,
   output logic                 oband_valid,
   output logic [BAND_W-1:0]    oband_idx,
   input  logic                 iband_ack,
   output logic                 oframe_done
);

   state_e state_q, state_d;

   logic [ADDR_W-1:0] col;
   logic [LANE_W-1:0] lane;
   logic [BAND_W-1:0] band;
   logic              col_last, lane_last, band_last;
   logic              cnt_clr, band_inc, accept;

   logic [DATA_W-1:0]    odata_q;
   logic [LANE_W-1:0]    osel_q;
   logic [NUM_LANES-1:0] owe_q;
   logic [ADDR_W-1:0]    oaddr_q;
   logic                 orow_done_q;
   logic                 band_valid_q, band_valid_d;
   logic [BAND_W-1:0]    band_idx_q, band_idx_d;

   // Ready and frame-done decode straight from the state register: no path from ivalid.
   assign oready      = (state_q == ST_RUN);
   assign oframe_done = (state_q == ST_DONE);
   assign accept      = ivalid & oready;

   mfhwt_raster_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_cnt (
      .clk         (iclk),
      .rst_n       (irst_n),
      .clr_i       (cnt_clr),
      .col_en_i    (accept),
      .band_inc_i  (band_inc),
      .col_o       (col),
      .lane_o      (lane),
      .band_o      (band),
      .col_last_o  (col_last),
      .lane_last_o (lane_last),
      .band_last_o (band_last)
   );

   always_comb begin
      state_d      = state_q;
      band_valid_d = band_valid_q;
      band_idx_d   = band_idx_q;
      cnt_clr      = 1'b0;
      band_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (istart) begin
               cnt_clr = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept && col_last && lane_last) begin
               band_valid_d = 1'b1;
               band_idx_d   = band;
               state_d      = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (iband_ack) begin
               band_valid_d = 1'b0;
               if (band_last) begin
                  state_d = ST_DONE;
               end else begin
                  band_inc = 1'b1;
                  state_d  = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q      <= ST_IDLE;
         band_valid_q <= 1'b0;
         band_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         band_valid_q <= band_valid_d;
         band_idx_q   <= band_idx_d;
      end
   end

   // Write-port registers: owe and orow_done pulse only on accepted pixels,
   // the remaining fields hold their last value between writes.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         odata_q     <= '0;
         osel_q      <= '0;
         owe_q       <= '0;
         oaddr_q     <= '0;
         orow_done_q <= 1'b0;
      end else begin
         owe_q       <= accept ? lane_onehot(lane) : '0;
         orow_done_q <= accept & col_last;
         if (accept) begin
            odata_q <= idata;
            osel_q  <= lane;
            oaddr_q <= col;
         end
      end
   end

   assign odata       = odata_q;
   assign osel        = osel_q;
   assign owe         = owe_q;
   assign oaddr       = oaddr_q;
   assign orow_done   = orow_done_q;
   assign oband_valid = band_valid_q;
   assign oband_idx   = band_idx_q;

endmodule

// File: tb/tb_mfhwt_demux_ctrl.sv
// Scoreboard bench for mfhwt_demux_ctrl at 8x8: expected buffer writes are queued
// as pixels are driven and popped when the write port fires.
module tb_mfhwt_demux_ctrl;

   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;
   localparam int DATA_W = 16;
   localparam int BAND_PIX = IMG_W * 4;

   logic              iclk = 1'b0;
   logic              irst_n;
   logic              istart;
   logic              ivalid;
   logic [DATA_W-1:0] idata;
   logic              iband_ack;
   logic              oready;
   logic [DATA_W-1:0] odata;
   logic [1:0]        osel;
   logic [3:0]        owe;
   logic [2:0]        oaddr;
   logic              orow_done;
   logic              oband_valid;
   logic [0:0]        oband_idx;
   logic              oframe_done;

   int n_vec = 0;
   int n_err = 0;
   logic [25:0] sb[$];

   mfhwt_demux_ctrl #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .DATA_W (DATA_W)
   ) dut (
      .iclk        (iclk),
      .irst_n      (irst_n),
      .istart      (istart),
      .ivalid      (ivalid),
      .idata       (idata),
      .oready      (oready),
      .odata       (odata),
      .osel        (osel),
      .owe         (owe),
      .oaddr       (oaddr),
      .orow_done   (orow_done),
      .oband_valid (oband_valid),
      .oband_idx   (oband_idx),
      .iband_ack   (iband_ack),
      .oframe_done (oframe_done)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected write word {data, sel, we, addr, row_done} for pixel p of a band.
   function automatic logic [25:0] exp_wr(input logic [DATA_W-1:0] d, input int p);
      int         lane;
      int         col;
      logic [3:0] oh;
      lane = (p / IMG_W) % 4;
      col  = p % IMG_W;
      oh   = 4'b0001 << lane;
      return {d, 2'(lane), oh, 3'(col), (col == IMG_W - 1)};
   endfunction

   function automatic logic [31:0] all_outs();
      return {2'b0, oready, odata, osel, owe, oaddr, orow_done, oband_valid, oband_idx, oframe_done};
   endfunction

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic drive_pix(input logic [DATA_W-1:0] d, input int p);
      ivalid = 1'b1;
      idata  = d;
      sb.push_back(exp_wr(d, p));
      tick();
   endtask

   // Write-port monitor: every owe pulse must match the oldest queued pixel.
   always @(negedge iclk) begin
      if (irst_n === 1'b1) begin
         if (owe !== 4'b0) begin
            if (sb.size() == 0)
               check("unexpected_write", {28'b0, owe}, 32'b0);
            else
               check("write", {6'b0, odata, osel, owe, oaddr, orow_done}, {6'b0, sb.pop_front()});
         end else if (orow_done !== 1'b0) begin
            check("row_done_without_write", {31'b0, orow_done}, 32'b0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;

      irst_n = 1'b1; istart = 1'b0; ivalid = 1'b0; iband_ack = 1'b0; idata = '0;
      #2 irst_n = 1'b0;

      // Reset with random inputs: everything held at zero.
      for (int i = 0; i < 4; i++) begin
         istart = 1'($urandom); ivalid = 1'($urandom); iband_ack = 1'($urandom); idata = 16'($urandom);
         #3 check("reset_outputs", all_outs(), 32'b0);
         #4;
      end
      istart = 1'b0; iband_ack = 1'b0;
      @(negedge iclk);
      irst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ivalid = 1'b1; idata = 16'($urandom);
         tick();
         check("idle_no_start", all_outs(), 32'b0);
      end
      ivalid = 1'b0;

      // Band 0: 32 back-to-back pixels.
      istart = 1'b1;
      tick();
      istart = 1'b0;
      for (int p = 0; p < BAND_PIX; p++) drive_pix(16'(p), p);
      ivalid = 1'b0;
      tick();
      check("band0_valid", {31'b0, oband_valid}, 1);
      check("band0_idx", {31'b0, oband_idx}, 0);
      check("band0_ready", {31'b0, oready}, 0);
      check("band0_sb_empty", sb.size(), 0);

      // Stall: source keeps offering, nothing is accepted.
      ivalid = 1'b1; idata = 16'hdead;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_ready", {31'b0, oready}, 0);
         check("stall_band_valid", {31'b0, oband_valid}, 1);
      end
      ivalid = 1'b0;
      iband_ack = 1'b1;
      tick();
      check("ack_band_valid", {31'b0, oband_valid}, 0);
      check("ack_ready", {31'b0, oready}, 1);

      // Band 1, ack still held for the first two pixels.
      for (int p = 0; p < BAND_PIX; p++) begin
         iband_ack = (p < 2);
         drive_pix(16'h0100 + 16'(p), p);
      end
      ivalid = 1'b0; iband_ack = 1'b0;
      tick();
      check("band1_valid", {31'b0, oband_valid}, 1);
      check("band1_idx", {31'b0, oband_idx}, 1);

      // Last ack ends the frame; istart during DONE must be ignored.
      iband_ack = 1'b1;
      tick();
      iband_ack = 1'b0; istart = 1'b1;
      check("frame_done_pulse", {31'b0, oframe_done}, 1);
      check("done_band_valid", {31'b0, oband_valid}, 0);
      check("done_ready", {31'b0, oready}, 0);
      tick();
      istart = 1'b0;
      check("frame_done_single", {31'b0, oframe_done}, 0);
      check("idle_ready", {31'b0, oready}, 0);
      tick();
      check("start_in_done_ignored", {31'b0, oready}, 0);
      check("frame_sb_empty", sb.size(), 0);

      // Random bubbles with spurious acks during RUN.
      istart = 1'b1;
      tick();
      istart = 1'b0;
      pushed = 0;
      for (int c = 0; c < 400 && pushed < BAND_PIX; c++) begin
         iband_ack = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0) begin
            drive_pix(16'($urandom), pushed);
            pushed++;
         end else begin
            ivalid = 1'b0;
            tick();
         end
      end
      ivalid = 1'b0; iband_ack = 1'b0;
      check("bubble_pixel_count", pushed, BAND_PIX);
      tick();
      check("bubble_band_valid", {31'b0, oband_valid}, 1);
      check("bubble_band_idx", {31'b0, oband_idx}, 0);
      check("bubble_sb_empty", sb.size(), 0);

      // Mid-frame reset at pixel 13 of band 1.
      iband_ack = 1'b1;
      tick();
      iband_ack = 1'b0;
      for (int p = 0; p < 13; p++) drive_pix(16'h0300 + 16'(p), p);
      ivalid = 1'b1; idata = 16'h0bad;
      @(negedge iclk);
      #1 irst_n = 1'b0;
      #1 check("midreset_outputs", all_outs(), 32'b0);
      check("midreset_sb_empty", sb.size(), 0);
      ivalid = 1'b0;
      @(negedge iclk);
      irst_n = 1'b1;
      tick();
      check("after_reset_idle", {31'b0, oready}, 0);
      check("after_reset_band_valid", {31'b0, oband_valid}, 0);
      istart = 1'b1;
      tick();
      istart = 1'b0;
      for (int p = 0; p < IMG_W; p++) drive_pix(16'h0400 + 16'(p), p);
      ivalid = 1'b0;
      tick();
      tick();
      check("restart_sb_empty", sb.size(), 0);
      check("restart_running", {31'b0, oready}, 1);
      check("restart_band_valid", {31'b0, oband_valid}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
